// File: rtl/alu_control_muldiv.sv
// alu_control_muldiv: ALU control decode for the EX stage, plus an iterative
// multiply/divide sequencer that owns HI/LO and stalls the pipeline while it
// runs.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   instruction[5:0]     funct field of the EX-stage instruction
//   ALUOp[1:0]           from main control
//   in_valid             EX instruction is real (not a bubble)
//   flush                kill EX instruction and any in-flight mul/div
//   a, b [WIDTH-1:0]     rs / rt operands (post-forwarding)
//   ALUcontrol[3:0]      ALU op code (combinational)
//   illegal              ALUOp=10 with undefined funct (combinational)
//   stall                freeze IF/ID/EX (combinational)
//   done                 one-cycle pulse while HI/LO show a fresh result
//   div_by_zero          sticky, set by a divide with b==0
//   hi, lo               HI / LO registers
module alu_control_muldiv #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       instruction,
  input  logic [1:0]       ALUOp,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       ALUcontrol,
  output logic             illegal,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [2*WIDTH-1:0]  acc_q;     // {partial/remainder, multiplier/quotient}
  logic [WIDTH-1:0]    opb_q;     // |multiplicand| or |divisor|
  logic [CNT_W-1:0]    cnt_q;
  logic                div_q, neg_q, rneg_q, dz_q, dzf_q;
  logic [WIDTH-1:0]    hi_q, lo_q;

  // ---------------- decode (pure combinational, no state) ----------------
  // Plain case (not casez/casex) so an X/Z funct falls to default.
  always_comb begin
    ALUcontrol = 4'b1111;
    illegal    = 1'b0;
    case (ALUOp)
      2'b00: ALUcontrol = 4'b0010;
      2'b01: ALUcontrol = 4'b0110;
      2'b11: ALUcontrol = 4'b0001;
      2'b10: begin
        case (instruction)
          6'b100000: ALUcontrol = 4'b0010;
          6'b100010: ALUcontrol = 4'b0110;
          6'b100100: ALUcontrol = 4'b0000;
          6'b100101: ALUcontrol = 4'b0001;
          6'b101010: ALUcontrol = 4'b0111;
          6'b101111: ALUcontrol = 4'b1000;
          6'b010000: ALUcontrol = 4'b1001;
          6'b010010: ALUcontrol = 4'b1010;
          6'b011000, 6'b011001,
          6'b011010, 6'b011011: ALUcontrol = 4'b1011;
          default: begin
            ALUcontrol = 4'b1111;
            illegal    = 1'b1;
          end
        endcase
      end
      default: ALUcontrol = 4'b1111;
    endcase
  end

  // funct 0110xx: bit1 selects divide, bit0 selects unsigned.
  logic is_md, accept, sgn;
  assign is_md  = in_valid && (ALUOp == 2'b10) && (instruction[5:2] == 4'b0110);
  assign accept = (state_q == S_IDLE) && is_md && !flush;
  assign sgn    = ~instruction[0];

  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_abs = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_abs = (sgn && b[WIDTH-1]) ? -b : b;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_BUSY;
      S_BUSY: begin
        if (flush)                        state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))      state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    stall = accept || ((state_q == S_BUSY) && !flush);
    done  = (state_q == S_DONE);
  end

  // ---------------- one iteration of mul or div ----------------
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH:0]   div_shl;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   q_raw, r_raw, hi_fin, lo_fin;

  always_comb begin
    // shift-add: add multiplicand into the upper half when LSB set, then shift
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // restoring divide: shift, trial subtract, keep if non-negative
    div_shl   = {acc_q, 1'b0};
    div_trial = div_shl[2*WIDTH:WIDTH] - {1'b0, opb_q};
    if (div_q)
      acc_step = div_trial[WIDTH] ? div_shl[2*WIDTH-1:0]
                                  : {div_trial[WIDTH-1:0], div_shl[WIDTH-1:1], 1'b1};
    else
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};

    prod  = neg_q ? -acc_step : acc_step;
    q_raw = acc_step[WIDTH-1:0];
    r_raw = acc_step[2*WIDTH-1:WIDTH];
    if (div_q) begin
      // b==0: restoring yields rem=|a|; restoring a's sign gives back a.
      lo_fin = dz_q ? '1 : (neg_q ? -q_raw : q_raw);
      hi_fin = rneg_q ? -r_raw : r_raw;
    end else begin
      lo_fin = prod[WIDTH-1:0];
      hi_fin = prod[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      dzf_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (accept) begin
      acc_q  <= {{WIDTH{1'b0}}, a_abs};
      opb_q  <= b_abs;
      cnt_q  <= CNT_W'(WIDTH);
      div_q  <= instruction[1];
      neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_q <= sgn && a[WIDTH-1] && instruction[1];
      dz_q   <= (b == '0);
      dzf_q  <= 1'b0;
    end else if ((state_q == S_BUSY) && !flush) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CNT_W'(1);
      // commit on the last iteration so HI/LO are valid throughout DONE
      if (cnt_q == CNT_W'(1)) begin
        hi_q <= hi_fin;
        lo_q <= lo_fin;
        if (div_q && dz_q) dzf_q <= 1'b1;
      end
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dzf_q;

endmodule

// File: tb/tb_alu_control_muldiv.sv
module tb_alu_control_muldiv;
  logic        clk = 1'b0;
  logic        reset, in_valid, flush;
  logic [5:0]  instruction;
  logic [1:0]  ALUOp;
  logic [31:0] a, b;
  logic [3:0]  ALUcontrol;
  logic        illegal, stall, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001,
                         F_DIV  = 6'b011010, F_DIVU  = 6'b011011;

  alu_control_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .ALUOp(ALUOp),
    .in_valid(in_valid), .flush(flush), .a(a), .b(b),
    .ALUcontrol(ALUcontrol), .illegal(illegal), .stall(stall), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a mul/div, count stalled cycles (bounded), then check DONE cycle.
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] av, bv,
                        input logic [31:0] exp_hi, exp_lo, input logic exp_dz);
    int n;
    n = 0;
    instruction = f; ALUOp = 2'b10; in_valid = 1'b1; a = av; b = bv;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall) break;
      n++;
      @(posedge clk); #1;
      // drop the instruction and scramble operands: latched copies must be used
      in_valid = 1'b0; a = $urandom; b = $urandom; instruction = 6'b100000;
    end
    chk({tag, ".stalls"}, 64'(n), 64'd33);
    chk({tag, ".done"},   64'(done), 64'd1);
    chk({tag, ".hi"},     64'(hi), 64'(exp_hi));
    chk({tag, ".lo"},     64'(lo), 64'(exp_lo));
    chk({tag, ".dz"},     64'(div_by_zero), 64'(exp_dz));
    tick();
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic accept_md(input logic [5:0] f, input logic [31:0] av, bv);
    instruction = f; ALUOp = 2'b10; in_valid = 1'b1; a = av; b = bv;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    instruction = 6'b0; ALUOp = 2'b00; a = '0; b = '0;
    tick(); tick();
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.done",  64'(done),  64'd0);
    chk("rst.hi",    64'(hi),    64'd0);
    chk("rst.lo",    64'(lo),    64'd0);
    chk("rst.dz",    64'(div_by_zero), 64'd0);
    reset = 1'b0;
    tick();

    // decode sweep (in_valid low so nothing starts)
    ALUOp = 2'b10;
    instruction = 6'b100000; #1 chk("dec.add", 64'({illegal, ALUcontrol}), 64'h02);
    instruction = 6'b100010; #1 chk("dec.sub", 64'({illegal, ALUcontrol}), 64'h06);
    instruction = 6'b100100; #1 chk("dec.and", 64'({illegal, ALUcontrol}), 64'h00);
    instruction = 6'b100101; #1 chk("dec.or",  64'({illegal, ALUcontrol}), 64'h01);
    instruction = 6'b101010; #1 chk("dec.slt", 64'({illegal, ALUcontrol}), 64'h07);
    instruction = 6'b101111; #1 chk("dec.sh",  64'({illegal, ALUcontrol}), 64'h08);
    instruction = 6'b010000; #1 chk("dec.mfhi", 64'({illegal, ALUcontrol}), 64'h09);
    instruction = 6'b010010; #1 chk("dec.mflo", 64'({illegal, ALUcontrol}), 64'h0A);
    instruction = F_DIVU;    #1 chk("dec.divu", 64'({illegal, ALUcontrol}), 64'h0B);
    instruction = 6'b111111; #1 chk("dec.ill", 64'({illegal, ALUcontrol}), 64'h1F);
    instruction = 6'bxxxxxx;
    ALUOp = 2'b00; #1 chk("dec.op00", 64'({illegal, ALUcontrol}), 64'h02);
    ALUOp = 2'b01; #1 chk("dec.op01", 64'({illegal, ALUcontrol}), 64'h06);
    ALUOp = 2'b11; #1 chk("dec.op11", 64'({illegal, ALUcontrol}), 64'h01);
    chk("dec.nostall", 64'(stall), 64'd0);
    tick();

    // mul/div results
    run_md("mult",  F_MULT, 32'd7,   32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_md("divu",  F_DIVU, 32'd100, 32'd7,        32'd2,        32'd14,       1'b0);
    run_md("div",   F_DIV,  32'hFFFFFFF9, 32'd2,   32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_md("divz",  F_DIVU, 32'h1234, 32'd0,       32'h1234,     32'hFFFFFFFF, 1'b1);
    run_md("multu", F_MULTU, 32'h10000, 32'h10000, 32'd1,        32'd0,        1'b0);
    run_md("sdivz", F_DIV,  32'hFFFFFF00, 32'd0,   32'hFFFFFF00, 32'hFFFFFFFF, 1'b1);
    run_md("mnm1",  F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,   32'h80000000, 1'b0);
    run_md("mults", F_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0,   32'd6,        1'b0);

    // flush on the 10th BUSY cycle; HI/LO keep {0,6}
    accept_md(F_MULT, 32'd5, 32'd6);
    repeat (9) tick();
    flush = 1'b1; #1;
    chk("fl.stall", 64'(stall), 64'd0);
    chk("fl.done",  64'(done),  64'd0);
    tick();
    flush = 1'b0;
    chk("fl.idle_done", 64'(done), 64'd0);
    chk("fl.hi", 64'(hi), 64'd0);
    chk("fl.lo", 64'(lo), 64'd6);
    run_md("fl.multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

    // reset (with simultaneous flush) in BUSY cycle 5
    accept_md(F_MULT, 32'd3, 32'd4);
    repeat (4) tick();
    chk("rb.busy", 64'(stall), 64'd1);
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; #1;
    chk("rb.stall", 64'(stall), 64'd0);
    chk("rb.done",  64'(done),  64'd0);
    chk("rb.hi",    64'(hi),    64'd0);
    chk("rb.lo",    64'(lo),    64'd0);
    tick();
    chk("rb.stays_idle", 64'(done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_control_muldiv.md
Name: alu_control_muldiv

Overview:
- Next-generation ALU control for the EX stage of the pipelined MIPS core.
- Decodes ALUOp/funct into the 4-bit ALUcontrol code, extended with the mult/multu/div/divu and mfhi/mflo funct codes.
- Owns an iterative multiply/divide sequencer with HI/LO registers, and stalls the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; rising edge
- reset  in  1  synchronous, active-high reset
- instruction  in  6  funct field of the EX-stage instruction
- ALUOp  in  2  from main control
- in_valid  in  1  EX-stage instruction valid (not a bubble)
- flush  in  1  kill the current EX instruction and any in-flight mul/div
- a  in  WIDTH  rs operand, after forwarding
- b  in  WIDTH  rt operand, after forwarding
- ALUcontrol  out  4  ALU operation code; combinational
- illegal  out  1  high for ALUOp=10 with an undefined funct; combinational
- stall  out  1  freeze IF/ID/EX; combinational
- done  out  1  one-cycle pulse when HI/LO are updated
- div_by_zero  out  1  sticky flag from the last divide; cleared by the next mul/div start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Decode (combinational, independent of state):
  - ALUOp 00 -> 0010 (add, lw/sw); 01 -> 0110 (sub, beq); 11 -> 0001 (or, ori).
  - ALUOp 10 funct: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 101010 slt 0111; 101111 shift 1000; 010000 mfhi 1001; 010010 mflo 1010.
  - ALUOp 10 funct 011000 mult / 011001 multu / 011010 div / 011011 divu -> 1011 (nop to ALU).
  - ALUOp 10 with any other funct -> 1111, illegal=1.
  - A funct containing X/Z must not match any case: 1111, illegal=1.
- is_md = in_valid & ALUOp==10 & funct in {011000..011011}.
- States IDLE, BUSY, DONE. Reset: state IDLE; hi=lo=0; done=0; div_by_zero=0; counter=0; stall=0.
- IDLE:
  - is_md & !flush: latch operands and op, take absolute values for signed ops, record result sign(s).
  - Clear div_by_zero, load counter=WIDTH, go to BUSY. stall=1 in this cycle.
- BUSY:
  - stall=1. One iteration per cycle: shift-add multiply or restoring divide. Counter decrements.
  - Counter reaches 1: go to DONE.
  - The accept cycle plus WIDTH BUSY cycles gives WIDTH+1 stalled cycles.
- DONE (one cycle):
  - hi/lo written with the final result; done=1; stall=0 so the instruction retires. Next state IDLE.
  - While in DONE a new is_md is not accepted; it is accepted in the following IDLE cycle.
- Multiply: {hi,lo} = 2*WIDTH-bit product. Signed mult negates the product when the operand signs differ.
- Divide: lo = quotient, hi = remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign (truncating division).
  - Division by zero (b==0): still takes the full latency; hi=a, lo=all ones, div_by_zero=1.
  - Signed most-negative ÷ -1: lo=most-negative, hi=0, no flag.
- flush:
  - In BUSY, or with is_md in IDLE: go to IDLE next cycle, hi/lo unchanged, no done pulse, stall=0 in the flush cycle.
  - Flush in DONE: DONE commit stands.
- Reset at any point overrides everything, including mid-operation and a simultaneous flush.
- mfhi/mflo in EX while BUSY are stalled by stall=1 and read the updated hi/lo from DONE onward. No separate interlock.
- Inputs a/b/instruction may change during BUSY without effect; latched copies are used.

Test Plan:
- Decode sweep: ALUOp=10 with funct 100000/100010/100100/100101/101010/101111 -> 0010/0110/0000/0001/0111/1000. ALUOp 00/01/11 with funct=6'bxxxxxx -> 0010/0110/0001. funct 111111 -> 1111, illegal=1.
- mult, WIDTH=32, a=7, b=0xFFFFFFFD:
  - stall high exactly 33 cycles.
  - done in cycle 34 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- divu a=100, b=7 -> lo=14, hi=2. Signed div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu b=0, a=0x1234 -> after 33 stall cycles hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1. A following multu clears the flag on accept.
- Start mult, assert flush on the 10th BUSY cycle:
  - stall drops that cycle; no done pulse.
  - hi/lo keep their prior values; a new multu is accepted the next cycle.
- Reset mid-BUSY (cycle 5) -> next cycle state IDLE, hi=lo=0, stall=0, done=0.
